// File: rtl/burst_packetizer.sv
// burst_packetizer: turns AXI write bursts and read requests into fixed-size packets
// queued in a small FIFO, tagged with a destination core taken from the address.
module burst_packetizer #(
    parameter int   ID_WIDTH          = 2,
    parameter int   DATA_WIDTH        = 32,
    parameter int   ADDR_WIDTH        = 32,
    parameter int   MAX_BURST_LEN     = 4,
    parameter int   NB_QUEUES         = 4,
    parameter int   UPPER_BOUND       = 15,
    parameter int   LOWER_BOUND       = 14,
    parameter logic PACKETIZER_NUMBER = 1'b0,
    parameter int   FIFO_DEPTH        = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [ID_WIDTH-1:0]           S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]           S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]           S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [1+ADDR_WIDTH+ID_WIDTH+8+MAX_BURST_LEN*(DATA_WIDTH/8+DATA_WIDTH)-1:0] packetOut,
    output logic                          packetValid,
    input  logic                          packetReady,
    output logic [$clog2(NB_QUEUES)-1:0]  coreId,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifoCount
);
    localparam int SW     = DATA_WIDTH / 8;
    localparam int BODY_W = MAX_BURST_LEN * (SW + DATA_WIDTH);
    localparam int PKT_W  = 1 + ADDR_WIDTH + ID_WIDTH + 8 + BODY_W;
    localparam int CORE_W = $clog2(NB_QUEUES);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = $clog2(MAX_BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, W_COLLECT, B_RESP} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [7:0]              len_q;
    logic [CORE_W-1:0]       core_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [SW-1:0]           strb_q [MAX_BURST_LEN];
    logic [SW-1:0]           strb_d [MAX_BURST_LEN];
    logic [DATA_WIDTH-1:0]   data_q [MAX_BURST_LEN];
    logic [DATA_WIDTH-1:0]   data_d [MAX_BURST_LEN];
    logic [MAX_BURST_LEN*SW-1:0]         strb_flat;
    logic [MAX_BURST_LEN*DATA_WIDTH-1:0] data_flat;
    logic [PKT_W-1:0]        mem [FIFO_DEPTH];
    logic [CORE_W-1:0]       core_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_q, rd_q;
    logic [CNT_W-1:0]        count_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic [ID_WIDTH-1:0]     bid_q;
    logic                    space, aw_hs, ar_hs, w_hs, wlast_hs, b_hs, push, pop, err;
    logic [PKT_W-1:0]        wr_pkt, rd_pkt, pkt_d;
    logic [CORE_W-1:0]       core_d;

    function automatic logic [ID_WIDTH-1:0] tag_id(input logic [ID_WIDTH-1:0] id);
        tag_id = id;
        tag_id[ID_WIDTH-1] = PACKETIZER_NUMBER;
    endfunction

    // Space is reserved when AW is taken: no read enters while a write is open.
    assign space         = count_q < CNT_W'(FIFO_DEPTH);
    assign S_AXI_AWREADY = !S_AXI_ARESET && state_q == IDLE && space;
    assign S_AXI_ARREADY = !S_AXI_ARESET && state_q == IDLE && space && !S_AXI_AWVALID;
    assign S_AXI_WREADY  = state_q == W_COLLECT;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;

    assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
    assign wlast_hs = w_hs && S_AXI_WLAST;
    assign b_hs     = bvalid_q && S_AXI_BREADY;
    assign push     = ar_hs || wlast_hs;
    assign pop      = packetValid && packetReady;
    // beat_q holds the beats seen before this one, saturated at MAX_BURST_LEN
    assign err      = 32'(len_q) >= MAX_BURST_LEN || 32'(beat_q) != 32'(len_q);

    always_comb begin
        strb_d    = strb_q;
        data_d    = data_q;
        strb_flat = '0;
        data_flat = '0;
        for (int i = 0; i < MAX_BURST_LEN; i++) begin
            if (aw_hs) begin
                strb_d[i] = '0;
                data_d[i] = '0;
            end else if (w_hs && beat_q == BEAT_W'(i)) begin
                strb_d[i] = S_AXI_WSTRB;
                data_d[i] = S_AXI_WDATA;
            end
            strb_flat[(MAX_BURST_LEN-1-i)*SW +: SW]                 = strb_d[i];
            data_flat[(MAX_BURST_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH] = data_d[i];
        end
    end

    assign wr_pkt = {1'b1, addr_q, tag_id(id_q), len_q, strb_flat, data_flat};
    assign rd_pkt = {1'b0, S_AXI_ARADDR, tag_id(S_AXI_ARID), S_AXI_ARLEN, {BODY_W{1'b0}}};
    assign pkt_d  = wlast_hs ? wr_pkt : rd_pkt;
    assign core_d = wlast_hs ? core_q : S_AXI_ARADDR[UPPER_BOUND:LOWER_BOUND];

    assign packetValid = count_q != '0;
    assign packetOut   = packetValid ? mem[rd_q] : '0;
    assign coreId      = packetValid ? core_mem[rd_q] : '0;
    assign fifoCount   = count_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem[wr_q]      <= pkt_d;
            core_mem[wr_q] <= core_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            core_q   <= '0;
            beat_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            bid_q    <= '0;
            for (int i = 0; i < MAX_BURST_LEN; i++) begin
                strb_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            strb_q  <= strb_d;
            data_q  <= data_d;
            wr_q    <= push ? wr_q + PTR_W'(1) : wr_q;
            rd_q    <= pop ? rd_q + PTR_W'(1) : rd_q;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= S_AXI_AWADDR;
                        id_q    <= S_AXI_AWID;
                        len_q   <= S_AXI_AWLEN;
                        core_q  <= S_AXI_AWADDR[UPPER_BOUND:LOWER_BOUND];
                        beat_q  <= '0;
                        state_q <= W_COLLECT;
                    end
                end
                W_COLLECT: begin
                    if (w_hs && beat_q != BEAT_W'(MAX_BURST_LEN))
                        beat_q <= beat_q + BEAT_W'(1);
                    if (wlast_hs) begin
                        bresp_q  <= err ? 2'b10 : 2'b00;
                        bid_q    <= id_q;
                        bvalid_q <= 1'b1;
                        state_q  <= B_RESP;
                    end
                end
                B_RESP: begin
                    if (b_hs) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_packetizer.sv
// tb_burst_packetizer: directed and randomized traffic against a queue-based
// packet model; every cycle the FIFO, handshake and response outputs are compared.
module tb_burst_packetizer;
    logic         clk, rst;
    logic [1:0]   AWID, ARID, BID, BRESP, coreId;
    logic [31:0]  AWADDR, ARADDR, WDATA;
    logic [7:0]   AWLEN, ARLEN;
    logic [3:0]   WSTRB;
    logic         AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY;
    logic [186:0] packetOut;
    logic         packetValid, packetReady;
    logic [2:0]   fifoCount;

    int n_chk = 0, n_err = 0;
    bit rand_prdy = 0;

    bit           w_open, b_pend;
    logic [31:0]  m_addr;
    logic [1:0]   m_id, exp_bresp, exp_bid;
    logic [7:0]   m_len;
    int           m_nb;
    logic [3:0]   m_s [4];
    logic [31:0]  m_d [4];
    logic [188:0] q [$];

    burst_packetizer dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN),
        .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST),
        .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
        .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .packetOut(packetOut), .packetValid(packetValid), .packetReady(packetReady),
        .coreId(coreId), .fifoCount(fifoCount)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet = {is_write, addr, tagged id, len} then strobes then data, beat 0 first.
    function automatic logic [186:0] mk(input bit wr, input logic [31:0] a, input logic [1:0] id,
                                        input logic [7:0] len);
        logic [186:0] p;
        p = 187'({wr, a, 1'b0, id[0], len});
        for (int i = 0; i < 4; i++) p = (p << 4) | 187'(wr ? m_s[i] : 4'h0);
        for (int i = 0; i < 4; i++) p = (p << 32) | 187'(wr ? m_d[i] : 32'h0);
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctl", {AWREADY, WREADY, ARREADY, BVALID, packetValid, BID, BRESP, coreId, fifoCount}, 0);
            chk("rst_pkt", packetOut, 0);
            q.delete();
            w_open = 0;
            b_pend = 0;
        end else begin
            chk("count", fifoCount, q.size());
            chk("pvalid", packetValid, q.size() != 0);
            chk("awready", AWREADY, !w_open && !b_pend && q.size() < 4);
            chk("arready", ARREADY, !w_open && !b_pend && q.size() < 4 && !AWVALID);
            chk("wready", WREADY, w_open);
            chk("bvalid", BVALID, b_pend);
            if (b_pend) chk("bresp_bid", {BRESP, BID}, {exp_bresp, exp_bid});
            if (packetValid && packetReady) begin
                if (q.size() == 0) chk("spurious_pkt", 1, 0);
                else begin
                    chk("pkt", packetOut, q[0][186:0]);
                    chk("core", coreId, q[0][188:187]);
                    void'(q.pop_front());
                end
            end
            if (ARVALID && ARREADY) q.push_back({ARADDR[15:14], mk(0, ARADDR, ARID, ARLEN)});
            if (AWVALID && AWREADY) begin
                w_open = 1;
                m_addr = AWADDR; m_id = AWID; m_len = AWLEN; m_nb = 0;
                for (int i = 0; i < 4; i++) begin m_s[i] = 0; m_d[i] = 0; end
            end
            if (WVALID && WREADY) begin
                if (m_nb < 4) begin m_s[m_nb] = WSTRB; m_d[m_nb] = WDATA; end
                m_nb++;
                if (WLAST) begin
                    q.push_back({m_addr[15:14], mk(1, m_addr, m_id, m_len)});
                    exp_bresp = (m_len >= 4 || m_nb != int'(m_len) + 1) ? 2'b10 : 2'b00;
                    exp_bid = m_id;
                    w_open = 0;
                    b_pend = 1;
                end
            end
            if (BVALID && BREADY) b_pend = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_prdy) packetReady = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic hs(input int ch);
        bit ok;
        int t = 0;
        do begin
            @(negedge clk);
            ok = ch == 0 ? AWREADY : ch == 1 ? WREADY : ch == 2 ? ARREADY : BVALID;
            @(posedge clk); #1;
            t++;
            if (rand_prdy) packetReady = 1'($urandom_range(0, 1));
        end while (!ok && t < 300);
        chk("handshake", ok, 1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] id, input logic [7:0] len);
        ARADDR = a; ARID = id; ARLEN = len; ARVALID = 1;
        hs(2);
        ARVALID = 0;
    endtask

    task automatic beats(input int nb, input logic [31:0] base, input int stop);
        for (int k = 0; k < nb && k < stop; k++) begin
            WDATA  = base != 0 ? base + 32'(k) : $urandom;
            WSTRB  = base != 0 ? 4'hF : 4'($urandom);
            WLAST  = k == nb - 1;
            WVALID = 1;
            hs(1);
        end
        WVALID = 0;
        WLAST  = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] id, input logic [7:0] len,
                      input int nb, input logic [31:0] base);
        AWADDR = a; AWID = id; AWLEN = len; AWVALID = 1;
        hs(0);
        AWVALID = 0;
        beats(nb, base, nb);
        idle($urandom_range(0, 2));
        BREADY = 1;
        hs(3);
        BREADY = 0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        rst = 1;
        {AWID, ARID, AWADDR, ARADDR, WDATA, AWLEN, ARLEN, WSTRB} = '0;
        {AWVALID, WLAST, WVALID, BREADY, ARVALID, packetReady} = '0;
        idle(3);
        rst = 0;
        packetReady = 1;
        idle(2);
        wr(32'h0000_8000, 2'd3, 8'd3, 4, 32'hA);
        idle(3);
        wr(32'h0000_4010, 2'd1, 8'd1, 2, 32'h100);
        wr(32'h0000_C020, 2'd2, 8'd5, 6, 32'h200);
        idle(3);
        packetReady = 0;
        for (int i = 0; i < 4; i++) rd(32'h1000 * i, 2'(i), 8'(i));
        ARADDR = 32'h0000_C000; ARID = 2'd3; ARLEN = 8'd7; ARVALID = 1;
        repeat (3) begin
            @(negedge clk);
            chk("full_arready", ARREADY, 0);
            chk("full_count", fifoCount, 4);
            @(posedge clk); #1;
        end
        packetReady = 1;
        hs(2);
        ARVALID = 0;
        idle(6);
        AWADDR = 32'h0000_4000; AWID = 2'd2; AWLEN = 8'd0; AWVALID = 1;
        ARADDR = 32'h0000_8004; ARID = 2'd1; ARLEN = 8'd0; ARVALID = 1;
        hs(0);
        AWVALID = 0;
        @(negedge clk);
        chk("ar_blocked", ARREADY, 0);
        @(posedge clk); #1;
        beats(1, 32'h300, 1);
        BREADY = 1;
        hs(3);
        BREADY = 0;
        hs(2);
        ARVALID = 0;
        idle(4);
        AWADDR = 32'h0000_8000; AWID = 2'd1; AWLEN = 8'd3; AWVALID = 1;
        hs(0);
        AWVALID = 0;
        beats(4, 32'h400, 2);
        WDATA = 32'h402; WVALID = 1;
        rst = 1;
        WVALID = 0;
        idle(2);
        rst = 0;
        idle(4);
        @(negedge clk);
        chk("post_rst_count", fifoCount, 0);
        chk("post_rst_pvalid", packetValid, 0);
        @(posedge clk); #1;
        ARVALID = 1;
        for (int i = 0; i < 8; i++) begin
            ARADDR = $urandom; ARID = 2'($urandom); ARLEN = 8'($urandom);
            @(negedge clk);
            chk("stream_arready", ARREADY, 1);
            chk("stream_count", fifoCount, i == 0 ? 0 : 1);
            @(posedge clk); #1;
        end
        ARVALID = 0;
        idle(3);
        rand_prdy = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(0, 5);
                wr($urandom, 2'($urandom), 8'(len),
                   $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : len + 1, 0);
            end else rd($urandom, 2'($urandom), 8'($urandom));
            idle($urandom_range(0, 2));
        end
        rand_prdy = 0;
        packetReady = 1;
        idle(10);
        @(negedge clk);
        chk("drained", fifoCount, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/burst_packetizer.md
BURST_PACKETIZER -- requirements
Module: burst_packetizer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2: AXI ID width; MSB of the packet ID is replaced by PACKETIZER_NUMBER.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI data width, multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 4: beats stored per write packet.
REQ-005 SHALL have parameter NB_QUEUES, default 4: number of destination core queues.
REQ-006 SHALL have parameters UPPER_BOUND, default 15, and LOWER_BOUND, default 14: address slice selecting core ID; UPPER_BOUND-LOWER_BOUND+1 = clog2(NB_QUEUES).
REQ-007 SHALL have parameter PACKETIZER_NUMBER, default 1'b0: source tag.
REQ-008 SHALL have parameter FIFO_DEPTH, default 4: output packet FIFO entries, power of two, >=2.
REQ-009 S_AXI_ACLK  in  1  sole clock, all state on rising edge.
REQ-010 S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-011 S_AXI_AW{ID,ADDR,LEN,VALID} in ID_WIDTH/ADDR_WIDTH/8/1; S_AXI_AWREADY out 1.
REQ-012 S_AXI_W{DATA,STRB,LAST,VALID} in DATA_WIDTH/DATA_WIDTH/8/1/1; S_AXI_WREADY out 1.
REQ-013 S_AXI_B{ID,RESP,VALID} out ID_WIDTH/2/1; S_AXI_BREADY in 1.
REQ-014 S_AXI_AR{ID,ADDR,LEN,VALID} in ID_WIDTH/ADDR_WIDTH/8/1; S_AXI_ARREADY out 1.
REQ-015 packetOut  out  META_W+MAX_BURST_LEN*(DATA_WIDTH/8+DATA_WIDTH)  {meta, strb[0..N-1], data[0..N-1]}, beat 0 most significant; META_W = 1+ADDR_WIDTH+ID_WIDTH+8 = {is_write, addr, tagged id, len}.
REQ-016 packetValid out 1, packetReady in 1, coreId out clog2(NB_QUEUES): valid/ready packet port, coreId travels with packet.
REQ-017 fifoCount  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-018 FSM states SHALL be IDLE, W_COLLECT, B_RESP.
REQ-019 In IDLE, AWREADY SHALL be 1 iff fifoCount<FIFO_DEPTH; ARREADY SHALL be 1 iff fifoCount<FIFO_DEPTH and AWVALID=0 (write priority on simultaneous AW/AR); both 0 in other states.
REQ-020 AR handshake SHALL push a read packet (is_write=0, strb/data all zero) into the FIFO at that edge; state stays IDLE; back-to-back reads SHALL sustain one per cycle.
REQ-021 AW handshake SHALL latch addr/id/len/coreId=AWADDR[UPPER_BOUND:LOWER_BOUND], clear beat counter, strb and data buffers, and enter W_COLLECT.
REQ-022 W_COLLECT: WREADY=1; each W handshake with counter<MAX_BURST_LEN SHALL store WDATA/WSTRB at index counter; counter increments saturating at MAX_BURST_LEN; beats beyond MAX_BURST_LEN are accepted and discarded.
REQ-023 W handshake with WLAST=1 SHALL push the write packet (is_write=1) into the FIFO at that edge, with that beat included, and enter B_RESP; unfilled beats carry strb=0, data=0.
REQ-024 BRESP SHALL be 2'b00, or 2'b10 (SLVERR) if AWLEN>=MAX_BURST_LEN or total beats != AWLEN+1; BID = latched AWID (untagged).
REQ-025 B_RESP: BVALID=1 until BVALID&BREADY, then IDLE; ID tagging: packet ID = {PACKETIZER_NUMBER, id[ID_WIDTH-2:0]}.
REQ-026 FIFO: packetValid = fifoCount!=0; pop on packetValid&packetReady; packetOut/coreId show head entry; push and pop same edge SHALL leave fifoCount unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 FIFO space SHALL be reserved at AW acceptance; no read is accepted while a write is outstanding, so the WLAST push never finds the FIFO full.
REQ-028 Latency: AR handshake to packetValid 1 cycle when FIFO empty; WLAST handshake to packetValid 1 cycle when FIFO empty.

Reset
REQ-029 While S_AXI_ARESET=1, state SHALL be IDLE, FIFO empty, fifoCount=0, and AWREADY, WREADY, ARREADY, BVALID, packetValid SHALL be 0; packetOut, coreId, BID, BRESP SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL discard the partial packet and all FIFO contents; no packet is emitted after release until a new handshake.

Verification
REQ-031 Write AWADDR=0x0000_8000, AWID=3, AWLEN=3, 4 beats 0xA..0xD, strb 0xF -> one packet, is_write=1, id=1, coreId=2, data beats 0xA..0xD, BRESP=00.
REQ-032 AWLEN=1, 2 beats -> beats 2..3 strb=0, data=0; BRESP=00; AWLEN=5 with 6 beats -> first 4 beats kept, BRESP=10.
REQ-033 packetReady=0, 5 reads issued -> 4 accepted, fifoCount=4, ARREADY=0; packetReady=1 -> packets drain in order, fifth read accepted.
REQ-034 AWVALID and ARVALID asserted same cycle -> write accepted first; read accepted only after B handshake.
REQ-035 Reset asserted after 2 of 4 write beats -> all outputs 0, fifoCount=0, no packet after release.
REQ-036 Continuous reads with packetReady=1 -> one packetValid per cycle, fifoCount stays 1.
